// File: rtl/branch_predictor.sv
// branch_predictor
//   IF-stage branch predictor: a direct-mapped BTB whose entries each hold a
//   2-bit saturating direction counter. The fetch PC is predicted
//   combinationally. The table trains on branches resolved in EX, and
//   mispredictions are flagged for the flush unit and the PC mux.
// Ports
//   clk_i, rst_i        clock (rising edge), async active-low reset
//   if_pc_i             fetch PC
//   pred_hit_o          BTB tag hit for if_pc_i
//   pred_taken_o        predicted taken
//   pred_target_o       predicted next PC
//   ex_*_i              resolved branch information from EX
//   mispredict_o        EX branch was mispredicted (flush request)
//   redirect_pc_o       correct next PC; 0 when no branch resolves
//   br_cnt_o            resolved-branch count (saturating)
//   miss_cnt_o          mispredict count (saturating)
module branch_predictor #(
  parameter int IDX_W = 4,
  parameter int PC_W  = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [PC_W-1:0] if_pc_i,
  output logic            pred_hit_o,
  output logic            pred_taken_o,
  output logic [PC_W-1:0] pred_target_o,
  input  logic            ex_valid_i,
  input  logic            ex_branch_i,
  input  logic [PC_W-1:0] ex_pc_i,
  input  logic            ex_taken_i,
  input  logic [PC_W-1:0] ex_target_i,
  input  logic            ex_pred_taken_i,
  input  logic [PC_W-1:0] ex_pred_target_i,
  output logic            mispredict_o,
  output logic [PC_W-1:0] redirect_pc_o,
  output logic [31:0]     br_cnt_o,
  output logic [31:0]     miss_cnt_o
);

  localparam int DEPTH = 2 ** IDX_W;
  localparam int TAG_W = PC_W - IDX_W - 2;
  localparam logic [PC_W-1:0] PC_INC  = PC_W'(4);
  localparam logic [31:0]     CNT_MAX = 32'hFFFF_FFFF;

  logic [DEPTH-1:0] r_valid;
  logic [TAG_W-1:0] r_tag    [DEPTH];
  logic [PC_W-1:0]  r_target [DEPTH];
  logic [1:0]       r_ctr    [DEPTH];
  logic [31:0]      r_br_cnt;
  logic [31:0]      r_miss_cnt;

  logic [IDX_W-1:0] w_if_idx;
  logic [TAG_W-1:0] w_if_tag;
  logic [IDX_W-1:0] w_ex_idx;
  logic [TAG_W-1:0] w_ex_tag;
  logic             w_ex_hit;
  logic             w_upd;
  logic             w_mispredict;

  assign w_if_idx = if_pc_i[IDX_W+1:2];
  assign w_if_tag = if_pc_i[PC_W-1:IDX_W+2];
  assign w_ex_idx = ex_pc_i[IDX_W+1:2];
  assign w_ex_tag = ex_pc_i[PC_W-1:IDX_W+2];

  // Prediction reads the registered table only, so a same-cycle train on
  // the same index is seen one cycle later.
  assign pred_hit_o    = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
  assign pred_taken_o  = pred_hit_o && r_ctr[w_if_idx][1];
  assign pred_target_o = pred_taken_o ? r_target[w_if_idx] : (if_pc_i + PC_INC);

  assign w_upd    = ex_valid_i && ex_branch_i;
  assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);

  // Target mismatch only matters when the branch is actually taken.
  assign w_mispredict = w_upd && ((ex_taken_i != ex_pred_taken_i) ||
                                  (ex_taken_i && (ex_target_i != ex_pred_target_i)));
  assign mispredict_o  = w_mispredict;
  assign redirect_pc_o = !w_upd     ? '0 :
                         ex_taken_i ? ex_target_i : (ex_pc_i + PC_INC);

  assign br_cnt_o   = r_br_cnt;
  assign miss_cnt_o = r_miss_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b01;
      end
    end else if (w_upd) begin
      if (w_ex_hit) begin
        if (ex_taken_i) begin
          r_target[w_ex_idx] <= ex_target_i;
          if (r_ctr[w_ex_idx] != 2'b11)
            r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + 2'd1;
        end else if (r_ctr[w_ex_idx] != 2'b00) begin
          r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - 2'd1;
        end
      end else if (ex_taken_i) begin
        // Miss on a taken branch allocates (or evicts an alias) weakly taken.
        r_valid[w_ex_idx]  <= 1'b1;
        r_tag[w_ex_idx]    <= w_ex_tag;
        r_target[w_ex_idx] <= ex_target_i;
        r_ctr[w_ex_idx]    <= 2'b10;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_br_cnt   <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_upd && (r_br_cnt != CNT_MAX))
        r_br_cnt <= r_br_cnt + 32'd1;
      if (w_mispredict && (r_miss_cnt != CNT_MAX))
        r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] if_pc_i = '0;
  logic        pred_hit_o, pred_taken_o;
  logic [31:0] pred_target_o;
  logic        ex_valid_i = 1'b0, ex_branch_i = 1'b0, ex_taken_i = 1'b0, ex_pred_taken_i = 1'b0;
  logic [31:0] ex_pc_i = '0, ex_target_i = '0, ex_pred_target_i = '0;
  logic        mispredict_o;
  logic [31:0] redirect_pc_o, br_cnt_o, miss_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  branch_predictor #(.IDX_W(4), .PC_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .if_pc_i(if_pc_i),
    .pred_hit_o(pred_hit_o), .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o),
    .ex_valid_i(ex_valid_i), .ex_branch_i(ex_branch_i), .ex_pc_i(ex_pc_i),
    .ex_taken_i(ex_taken_i), .ex_target_i(ex_target_i),
    .ex_pred_taken_i(ex_pred_taken_i), .ex_pred_target_i(ex_pred_target_i),
    .mispredict_o(mispredict_o), .redirect_pc_o(redirect_pc_o),
    .br_cnt_o(br_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: 16 entries addressed by (pc/4) mod 16, tag = pc/64.
  bit          m_valid [16];
  longint      m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  longint      m_br, m_miss;
  localparam longint SAT = 64'h0000_0000_FFFF_FFFF;

  function automatic int idx_of(logic [31:0] pc);
    return int'((longint'(pc) / 4) % 16);
  endfunction

  function automatic longint tag_of(logic [31:0] pc);
    return longint'(pc) / 64;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = '0; m_ctr[i] = 1;
    end
    m_br = 0; m_miss = 0;
  endtask

  task automatic model_pred(input logic [31:0] pc, output logic hit, output logic tk,
                            output logic [31:0] tgt);
    int i;
    i   = idx_of(pc);
    hit = m_valid[i] && (m_tag[i] == tag_of(pc));
    tk  = hit && (m_ctr[i] >= 2);
    tgt = tk ? m_tgt[i] : 32'((longint'(pc) + 4) % 64'h1_0000_0000);
  endtask

  task automatic model_resolve(output logic mp, output logic [31:0] rd);
    bit upd;
    upd = ex_valid_i && ex_branch_i;
    mp  = upd && ((ex_taken_i != ex_pred_taken_i) ||
                  (ex_taken_i && ex_target_i != ex_pred_target_i));
    if (!upd)            rd = '0;
    else if (ex_taken_i) rd = ex_target_i;
    else                 rd = 32'((longint'(ex_pc_i) + 4) % 64'h1_0000_0000);
  endtask

  // Applies the current EX inputs to the model, as the clock edge does.
  task automatic model_train();
    logic mp; logic [31:0] rd; int i; bit hit;
    model_resolve(mp, rd);
    if (!(ex_valid_i && ex_branch_i)) return;
    i   = idx_of(ex_pc_i);
    hit = m_valid[i] && (m_tag[i] == tag_of(ex_pc_i));
    if (hit) begin
      if (ex_taken_i) begin
        m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
        m_tgt[i] = ex_target_i;
      end else begin
        m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
      end
    end else if (ex_taken_i) begin
      m_valid[i] = 1; m_tag[i] = tag_of(ex_pc_i); m_tgt[i] = ex_target_i; m_ctr[i] = 2;
    end
    m_br = (m_br + 1 > SAT) ? SAT : m_br + 1;
    if (mp) m_miss = (m_miss + 1 > SAT) ? SAT : m_miss + 1;
  endtask

  task automatic drive_ex(input bit v, input bit b, input logic [31:0] pc, input bit tk,
                          input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt);
    ex_valid_i = v; ex_branch_i = b; ex_pc_i = pc; ex_taken_i = tk;
    ex_target_i = tgt; ex_pred_taken_i = ptk; ex_pred_target_i = ptgt;
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_train();
    #1;
    drive_ex(0, 0, '0, 0, '0, 0, '0);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    model_reset();
    #12 rst_i = 1'b1;
    @(posedge clk_i); #1;
    if_pc_i = 32'h100; #1;
    n_checks++; if (pred_hit_o !== 1'b0) begin n_fail++; $display("FAIL reset_hit got=%b exp=0", pred_hit_o); end
    n_checks++; if (pred_taken_o !== 1'b0) begin n_fail++; $display("FAIL reset_taken got=%b exp=0", pred_taken_o); end
    n_checks++; if (pred_target_o !== 32'h104) begin n_fail++; $display("FAIL reset_target got=%h exp=00000104", pred_target_o); end
    n_checks++; if (br_cnt_o !== 32'd0 || miss_cnt_o !== 32'd0) begin n_fail++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", br_cnt_o, miss_cnt_o); end
    n_checks++; if (mispredict_o !== 1'b0 || redirect_pc_o !== 32'd0) begin n_fail++; $display("FAIL reset_idle_resolve got=%b/%h exp=0/0", mispredict_o, redirect_pc_o); end
    if_pc_i = 32'hFFFF_FFFC; #1;
    n_checks++; if (pred_target_o !== 32'h0) begin n_fail++; $display("FAIL pc_wrap got=%h exp=00000000", pred_target_o); end
  endtask

  task automatic test_train_taken();
    drive_ex(1, 1, 32'h100, 1, 32'h200, 0, 32'h0);
    if_pc_i = 32'h100; #1;
    n_checks++; if (mispredict_o !== 1'b1 || redirect_pc_o !== 32'h200) begin n_fail++; $display("FAIL alloc_resolve got=%b/%h exp=1/00000200", mispredict_o, redirect_pc_o); end
    n_checks++; if (pred_hit_o !== 1'b0) begin n_fail++; $display("FAIL no_bypass got=%b exp=0", pred_hit_o); end
    tick();
    n_checks++; if (pred_hit_o !== 1'b1 || pred_taken_o !== 1'b1 || pred_target_o !== 32'h200) begin n_fail++; $display("FAIL alloc_predict got=%b/%b/%h exp=1/1/00000200", pred_hit_o, pred_taken_o, pred_target_o); end
  endtask

  task automatic test_not_taken();
    drive_ex(1, 1, 32'h100, 0, 32'h200, 1, 32'h200); #1;
    n_checks++; if (mispredict_o !== 1'b1 || redirect_pc_o !== 32'h104) begin n_fail++; $display("FAIL nt_resolve got=%b/%h exp=1/00000104", mispredict_o, redirect_pc_o); end
    tick();
    drive_ex(1, 1, 32'h100, 0, 32'h200, 1, 32'h200);
    tick();
    if_pc_i = 32'h100; #1;
    n_checks++; if (pred_hit_o !== 1'b1 || pred_taken_o !== 1'b0 || pred_target_o !== 32'h104) begin n_fail++; $display("FAIL nt_predict got=%b/%b/%h exp=1/0/00000104", pred_hit_o, pred_taken_o, pred_target_o); end
    // ctr is now 00: one taken resolve must leave it not-taken (01).
    drive_ex(1, 1, 32'h100, 1, 32'h200, 0, 32'h0);
    tick();
    n_checks++; if (pred_taken_o !== 1'b0) begin n_fail++; $display("FAIL ctr_from_00 got=%b exp=0", pred_taken_o); end
  endtask

  task automatic test_alias();
    drive_ex(1, 1, 32'h140, 1, 32'h300, 0, 32'h0);
    tick();
    if_pc_i = 32'h100; #1;
    n_checks++; if (pred_hit_o !== 1'b0 || pred_target_o !== 32'h104) begin n_fail++; $display("FAIL alias_evicted got=%b/%h exp=0/00000104", pred_hit_o, pred_target_o); end
    if_pc_i = 32'h140; #1;
    n_checks++; if (pred_hit_o !== 1'b1 || pred_taken_o !== 1'b1 || pred_target_o !== 32'h300) begin n_fail++; $display("FAIL alias_hit got=%b/%b/%h exp=1/1/00000300", pred_hit_o, pred_taken_o, pred_target_o); end
  endtask

  task automatic test_target_mismatch();
    longint miss_before;
    miss_before = m_miss;
    drive_ex(1, 1, 32'h140, 1, 32'h204, 1, 32'h200); #1;
    n_checks++; if (mispredict_o !== 1'b1 || redirect_pc_o !== 32'h204) begin n_fail++; $display("FAIL tgt_mismatch got=%b/%h exp=1/00000204", mispredict_o, redirect_pc_o); end
    tick();
    n_checks++; if (miss_cnt_o !== 32'(miss_before + 1) || br_cnt_o !== 32'(m_br)) begin n_fail++; $display("FAIL tgt_counts got=%0d/%0d exp=%0d/%0d", br_cnt_o, miss_cnt_o, m_br, miss_before + 1); end
    if_pc_i = 32'h140; #1;
    n_checks++; if (pred_target_o !== 32'h204) begin n_fail++; $display("FAIL tgt_retrain got=%h exp=00000204", pred_target_o); end
    // Correct direction and target: no mispredict.
    drive_ex(1, 1, 32'h140, 1, 32'h204, 1, 32'h204); #1;
    n_checks++; if (mispredict_o !== 1'b0) begin n_fail++; $display("FAIL correct_pred got=%b exp=0", mispredict_o); end
    tick();
  endtask

  task automatic test_gated_and_async_reset();
    logic [31:0] br0, miss0;
    br0 = br_cnt_o; miss0 = miss_cnt_o;
    drive_ex(0, 1, 32'h140, 1, 32'h500, 0, 32'h0); #1;
    n_checks++; if (mispredict_o !== 1'b0 || redirect_pc_o !== 32'h0) begin n_fail++; $display("FAIL gated_resolve got=%b/%h exp=0/0", mispredict_o, redirect_pc_o); end
    @(posedge clk_i); model_train(); #1;
    drive_ex(1, 0, 32'h140, 1, 32'h500, 0, 32'h0);
    @(posedge clk_i); model_train(); #1;
    drive_ex(0, 0, '0, 0, '0, 0, '0);
    if_pc_i = 32'h140; #1;
    n_checks++; if (br_cnt_o !== br0 || miss_cnt_o !== miss0 || pred_target_o !== 32'h204) begin n_fail++; $display("FAIL gated_nochange got=%0d/%0d/%h exp=%0d/%0d/00000204", br_cnt_o, miss_cnt_o, pred_target_o, br0, miss0); end
    n_checks++; if (br_cnt_o !== 32'(m_br) || miss_cnt_o !== 32'(m_miss)) begin n_fail++; $display("FAIL directed_counts got=%0d/%0d exp=%0d/%0d", br_cnt_o, miss_cnt_o, m_br, m_miss); end
    #1 rst_i = 1'b0; #1;
    n_checks++; if (pred_hit_o !== 1'b0 || pred_target_o !== 32'h144 || br_cnt_o !== 32'd0 || miss_cnt_o !== 32'd0) begin n_fail++; $display("FAIL async_reset got=%b/%h/%0d/%0d exp=0/00000144/0/0", pred_hit_o, pred_target_o, br_cnt_o, miss_cnt_o); end
    model_reset();
    @(negedge clk_i); rst_i = 1'b1;
    @(posedge clk_i); #2;
  endtask

  task automatic test_random();
    logic hit, tk, mp; logic [31:0] tgt, rd, pc;
    for (int n = 0; n < 400; n++) begin
      if_pc_i = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
      pc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
      drive_ex($urandom_range(0, 7) != 0, $urandom_range(0, 5) != 0, pc,
               $urandom_range(0, 1) == 1, {$urandom_range(0, 255), 2'b00} + 32'h1000,
               $urandom_range(0, 1) == 1, 32'h0);
      ex_pred_target_i = $urandom_range(0, 1) ? ex_target_i : ex_target_i + 32'd4;
      #1;
      model_pred(if_pc_i, hit, tk, tgt);
      model_resolve(mp, rd);
      n_checks++; if (pred_hit_o !== hit || pred_taken_o !== tk || pred_target_o !== tgt) begin n_fail++; $display("FAIL rnd_predict pc=%h got=%b/%b/%h exp=%b/%b/%h", if_pc_i, pred_hit_o, pred_taken_o, pred_target_o, hit, tk, tgt); end
      n_checks++; if (mispredict_o !== mp || redirect_pc_o !== rd) begin n_fail++; $display("FAIL rnd_resolve got=%b/%h exp=%b/%h", mispredict_o, redirect_pc_o, mp, rd); end
      @(posedge clk_i); model_train(); #1;
      n_checks++; if (br_cnt_o !== 32'(m_br) || miss_cnt_o !== 32'(m_miss)) begin n_fail++; $display("FAIL rnd_counts got=%0d/%0d exp=%0d/%0d", br_cnt_o, miss_cnt_o, m_br, m_miss); end
    end
    drive_ex(0, 0, '0, 0, '0, 0, '0);
  endtask

  initial begin
    test_reset();
    test_train_taken();
    test_not_taken();
    test_alias();
    test_target_mismatch();
    test_gated_and_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
